// File: rtl/voter_session.sv
`default_nettype none
// ============================================================================
//  Module      : voter_session
//  Description : Timed voting session for N_VOTERS voters. A session opens
//                on start. Each voter's first ballot inside the window is
//                kept, and a repeat strobe raises the sticky dup_err flag.
//                The session closes early once every voter has voted, or
//                after WINDOW open cycles, or it is cancelled by abort.
//                A single EVAL cycle then counts the ballots and publishes a
//                registered one-hot verdict {pass, tie, fail}. The verdict
//                uses simple-majority mode or quorum mode, as latched at start.
//
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                start      - open a session (honoured in IDLE only)
//                abort      - cancel an open session
//                mode       - 0 = simple majority, 1 = quorum (latched)
//                vote_valid - per-voter ballot strobe
//                vote_val   - per-voter ballot value (1 = yes, 0 = no)
//                busy       - session open or being evaluated
//                done       - one-cycle pulse when a verdict is published
//                result     - one-hot {pass, tie, fail}, 3'b000 = none
//                yes_cnt    - yes ballots
//                no_cnt     - no ballots
//                abst_cnt   - voters that did not vote
//                dup_err    - sticky repeat-ballot flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module voter_session #(
  parameter  int N_VOTERS = 4,
  parameter  int WINDOW   = 8,
  parameter  int QUORUM   = 3,
  localparam int CNT_W    = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic                busy,
  output logic                done,
  output logic [2:0]          result,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic [CNT_W-1:0]    abst_cnt,
  output logic                dup_err
);

  // A one-cycle window still needs a one-bit timer.
  localparam int               TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] QUORUM_C = CNT_W'(QUORUM);
  localparam logic [CNT_W-1:0] NVOTE_C  = CNT_W'(N_VOTERS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPEN = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_PASS = 3'b100;
  localparam logic [2:0] RES_TIE  = 3'b010;
  localparam logic [2:0] RES_FAIL = 3'b001;

  logic [1:0]          state_q,  state_d;
  logic                mode_q,   mode_d;
  logic [N_VOTERS-1:0] voted_q,  voted_d;
  logic [N_VOTERS-1:0] ballot_q, ballot_d;
  logic [TMR_W-1:0]    timer_q,  timer_d;
  logic                dup_q,    dup_d;
  logic                done_q,   done_d;
  logic [2:0]          result_q, result_d;
  logic [CNT_W-1:0]    yes_q,    yes_d;
  logic [CNT_W-1:0]    no_q,     no_d;
  logic [CNT_W-1:0]    abst_q,   abst_d;

  // Voter bookkeeping after this cycle's strobes are applied.
  logic [N_VOTERS-1:0] voted_now;
  logic [N_VOTERS-1:0] ballot_now;
  logic                dup_now;
  logic                all_voted;
  logic                timer_last;
  logic [CNT_W-1:0]    yes_sum;
  logic [CNT_W-1:0]    no_sum;

  // --------------------------------------------------------------------------
  // Ballot merge: only a voter's first strobe captures its value. The
  // closing-cycle check uses the merged vector, so a ballot that completes
  // the electorate closes the window in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    voted_now  = voted_q | vote_valid;
    ballot_now = ballot_q | (vote_val & vote_valid & ~voted_q);
    dup_now    = |(vote_valid & voted_q);
    all_voted  = &voted_now;
    timer_last = (timer_q == TMR_LAST);
  end

  // Tallies over the ballots held at EVAL. ballot_q is kept zero for
  // non-voters, but it is masked anyway so the counts never depend on that.
  always_comb begin
    yes_sum = '0;
    no_sum  = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      yes_sum = yes_sum + CNT_W'(voted_q[i] &  ballot_q[i]);
      no_sum  = no_sum  + CNT_W'(voted_q[i] & ~ballot_q[i]);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. In OPEN, abort has priority over closing.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (all_voted || timer_last) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    mode_d   = mode_q;
    voted_d  = voted_q;
    ballot_d = ballot_q;
    timer_d  = timer_q;
    dup_d    = dup_q;
    done_d   = 1'b0;
    result_d = result_q;
    yes_d    = yes_q;
    no_d     = no_q;
    abst_d   = abst_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          voted_d  = '0;
          ballot_d = '0;
          timer_d  = '0;
          dup_d    = 1'b0;
          result_d = RES_NONE;
          yes_d    = '0;
          no_d     = '0;
          abst_d   = '0;
        end
      end
      S_OPEN: begin
        voted_d  = voted_now;
        ballot_d = ballot_now;
        if (dup_now) begin
          dup_d = 1'b1;
        end
        if (!abort && !all_voted && !timer_last) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_EVAL: begin
        yes_d  = yes_sum;
        no_d   = no_sum;
        abst_d = NVOTE_C - yes_sum - no_sum;
        done_d = 1'b1;
        if (mode_q) begin
          result_d = (yes_sum >= QUORUM_C) ? RES_PASS : RES_FAIL;
        end else if (yes_sum > no_sum) begin
          result_d = RES_PASS;
        end else if (yes_sum == no_sum) begin
          result_d = RES_TIE;
        end else begin
          result_d = RES_FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      voted_q  <= '0;
      ballot_q <= '0;
      timer_q  <= '0;
      dup_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= RES_NONE;
      yes_q    <= '0;
      no_q     <= '0;
      abst_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      voted_q  <= voted_d;
      ballot_q <= ballot_d;
      timer_q  <= timer_d;
      dup_q    <= dup_d;
      done_q   <= done_d;
      result_q <= result_d;
      yes_q    <= yes_d;
      no_q     <= no_d;
      abst_q   <= abst_d;
    end
  end

  assign busy     = (state_q == S_OPEN) || (state_q == S_EVAL);
  assign done     = done_q;
  assign result   = result_q;
  assign yes_cnt  = yes_q;
  assign no_cnt   = no_q;
  assign abst_cnt = abst_q;
  assign dup_err  = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_voter_session.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_voter_session
//  Description : Self-checking bench for voter_session (N=4, WINDOW=8,
//                QUORUM=3). Each session is described by a per-cycle ballot
//                plan. The expected close cycle, dup_err timeline, counts and
//                verdict are worked out from the session rules over plain
//                arrays before the plan is driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voter_session;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int Q  = 3;
  localparam int CW = 3;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          mode       = 1'b0;
  logic [N-1:0]  vote_valid = '0;
  logic [N-1:0]  vote_val   = '0;
  logic          busy;
  logic          done;
  logic [2:0]    result;
  logic [CW-1:0] yes_cnt;
  logic [CW-1:0] no_cnt;
  logic [CW-1:0] abst_cnt;
  logic          dup_err;

  int n_cmp = 0;
  int n_err = 0;

  // Per-cycle ballot plan for the next session.
  logic [N-1:0] plan_vv [W];
  logic [N-1:0] plan_vl [W];

  // Values that must hold after the most recent session.
  logic [2:0] last_res  = 3'b000;
  int         last_yes  = 0;
  int         last_no   = 0;
  int         last_abst = 0;
  bit         last_dup  = 1'b0;

  voter_session #(
    .N_VOTERS (N),
    .WINDOW   (W),
    .QUORUM   (Q)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .vote_valid (vote_valid),
    .vote_val   (vote_val),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .yes_cnt    (yes_cnt),
    .no_cnt     (no_cnt),
    .abst_cnt   (abst_cnt),
    .dup_err    (dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int c = 0; c < W; c++) begin
      plan_vv[c] = '0;
      plan_vl[c] = '0;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   32'(busy),     32'(0));
    chk({tag, "_done"},   32'(done),     32'(0));
    chk({tag, "_result"}, 32'(result),   32'(last_res));
    chk({tag, "_yes"},    32'(yes_cnt),  32'(last_yes));
    chk({tag, "_no"},     32'(no_cnt),   32'(last_no));
    chk({tag, "_abst"},   32'(abst_cnt), 32'(last_abst));
    chk({tag, "_dup"},    32'(dup_err),  32'(last_dup));
  endtask

  // Run one session from IDLE using plan_vv/plan_vl.
  //   abort_at    : OPEN cycle that raises abort (-1 = never)
  //   start_abort : raise abort together with start in IDLE
  //   noise       : toggle mode/start during OPEN, drive junk in EVAL/IDLE
  task automatic run_session(input bit m, input int abort_at,
                             input bit start_abort, input bit noise);
    logic [N-1:0] voted;
    logic [N-1:0] ballot;
    bit           dup_at [W];
    bit           dup;
    bit           aborted;
    int           close_c;
    int           y;
    int           n;
    logic [2:0]   exp_res;

    // Expected outcome from the session rules.
    voted   = '0;
    ballot  = '0;
    dup     = 1'b0;
    aborted = 1'b0;
    close_c = W - 1;
    for (int c = 0; c < W; c++) begin
      dup_at[c] = 1'b0;
    end
    for (int c = 0; c < W; c++) begin
      for (int i = 0; i < N; i++) begin
        if (plan_vv[c][i]) begin
          if (voted[i]) begin
            dup = 1'b1;
          end else begin
            voted[i]  = 1'b1;
            ballot[i] = plan_vl[c][i];
          end
        end
      end
      dup_at[c] = dup;
      if (c == abort_at) begin
        aborted = 1'b1;
        close_c = c;
        break;
      end
      if (voted == '1) begin
        close_c = c;
        break;
      end
    end
    y = 0;
    n = 0;
    for (int i = 0; i < N; i++) begin
      if (voted[i]) begin
        if (ballot[i]) y++;
        else           n++;
      end
    end
    if (m)          exp_res = (y >= Q) ? 3'b100 : 3'b001;
    else if (y > n) exp_res = 3'b100;
    else if (y == n) exp_res = 3'b010;
    else            exp_res = 3'b001;

    // Open the session.
    start = 1'b1;
    abort = start_abort;
    mode  = m;
    if (noise) begin
      vote_valid = 4'($urandom);
      vote_val   = 4'($urandom);
    end
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("open_busy",  32'(busy),     32'(1));
    chk("open_res",   32'(result),   32'(0));
    chk("open_yes",   32'(yes_cnt),  32'(0));
    chk("open_no",    32'(no_cnt),   32'(0));
    chk("open_abst",  32'(abst_cnt), 32'(0));
    chk("open_dup",   32'(dup_err),  32'(0));

    for (int c = 0; c <= close_c; c++) begin
      vote_valid = plan_vv[c];
      vote_val   = plan_vl[c];
      abort      = (c == abort_at);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
      end
      tick();
      chk("dup_err", 32'(dup_err), 32'(dup_at[c]));
      chk("no_early_done", 32'(done), 32'(0));
      if (c < close_c) begin
        chk("still_open", 32'(busy), 32'(1));
      end
    end
    start      = 1'b0;
    abort      = 1'b0;
    vote_valid = '0;
    vote_val   = '0;

    if (aborted) begin
      last_res  = 3'b000;
      last_yes  = 0;
      last_no   = 0;
      last_abst = 0;
      last_dup  = dup_at[close_c];
      chk_idle_outputs("abort");
      if (noise) begin
        vote_valid = 4'($urandom);
        abort      = 1'b1;
      end
      tick();
      vote_valid = '0;
      abort      = 1'b0;
      chk_idle_outputs("abort_after");
    end else begin
      chk("eval_busy", 32'(busy), 32'(1));
      if (noise) begin
        vote_valid = 4'($urandom);
        vote_val   = 4'($urandom);
        abort      = 1'($urandom_range(0, 1));
        start      = 1'($urandom_range(0, 1));
      end
      tick();
      vote_valid = '0;
      vote_val   = '0;
      abort      = 1'b0;
      start      = 1'b0;
      chk("done_pulse", 32'(done),     32'(1));
      chk("verdict",    32'(result),   32'(exp_res));
      chk("yes_cnt",    32'(yes_cnt),  32'(y));
      chk("no_cnt",     32'(no_cnt),   32'(n));
      chk("abst_cnt",   32'(abst_cnt), 32'(N - y - n));
      chk("post_busy",  32'(busy),     32'(0));
      chk("post_dup",   32'(dup_err),  32'(dup));
      last_res  = exp_res;
      last_yes  = y;
      last_no   = n;
      last_abst = N - y - n;
      last_dup  = dup;
      tick();
      chk_idle_outputs("hold");
    end
  endtask

  initial begin
    // Power-on reset.
    rst_n = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Early close: three yes in cycle 0, one no in cycle 2.
    clear_plan();
    plan_vv[0] = 4'b0111; plan_vl[0] = 4'b0111;
    plan_vv[2] = 4'b1000; plan_vl[2] = 4'b0000;
    run_session(1'b0, -1, 1'b0, 1'b0);

    // Timeout tie, then a session with no ballots at all.
    clear_plan();
    plan_vv[0] = 4'b0011; plan_vl[0] = 4'b0001;
    run_session(1'b0, -1, 1'b0, 1'b0);
    clear_plan();
    run_session(1'b0, -1, 1'b0, 1'b0);

    // Duplicate ballot from voter 0.
    clear_plan();
    plan_vv[0] = 4'b0001; plan_vl[0] = 4'b0001;
    plan_vv[3] = 4'b0001; plan_vl[3] = 4'b0000;
    run_session(1'b0, -1, 1'b0, 1'b0);

    // Quorum: 2 yes fails, 3 yes + 1 no passes (mode/start toggled while open).
    clear_plan();
    plan_vv[1] = 4'b0011; plan_vl[1] = 4'b0011;
    run_session(1'b1, -1, 1'b0, 1'b0);
    clear_plan();
    plan_vv[0] = 4'b0101; plan_vl[0] = 4'b0101;
    plan_vv[5] = 4'b1010; plan_vl[5] = 4'b0010;
    run_session(1'b1, -1, 1'b0, 1'b1);

    // Abort in cycle 4, then start+abort together in IDLE, full window.
    clear_plan();
    plan_vv[1] = 4'b0110; plan_vl[1] = 4'b0100;
    run_session(1'b0, 4, 1'b0, 1'b0);
    clear_plan();
    plan_vv[2] = 4'b0001; plan_vl[2] = 4'b0000;
    run_session(1'b0, -1, 1'b1, 1'b0);

    // Randomized sessions with idle gaps.
    for (int s = 0; s < 60; s++) begin
      int gap;
      for (int c = 0; c < W; c++) begin
        plan_vv[c] = 4'($urandom) & 4'($urandom);
        plan_vl[c] = 4'($urandom);
      end
      run_session(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        abort      = 1'($urandom_range(0, 1));
        vote_valid = 4'($urandom);
        vote_val   = 4'($urandom);
        tick();
        chk_idle_outputs("gap");
      end
      abort      = 1'b0;
      vote_valid = '0;
      vote_val   = '0;
    end

    // Reset asserted mid-session, checked between clock edges.
    clear_plan();
    plan_vv[0] = 4'b0001; plan_vl[0] = 4'b0001;
    start = 1'b1;
    mode  = 1'b0;
    tick();
    start      = 1'b0;
    vote_valid = 4'b0001;
    vote_val   = 4'b0001;
    tick();
    vote_valid = 4'b0001;
    tick();
    vote_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    last_res  = 3'b000;
    last_yes  = 0;
    last_no   = 0;
    last_abst = 0;
    last_dup  = 1'b0;
    chk_idle_outputs("async_rst");
    tick();
    tick();
    chk_idle_outputs("rst_hold");
    rst_n = 1'b1;
    tick();

    // Recovery after reset.
    clear_plan();
    plan_vv[0] = 4'b1111; plan_vl[0] = 4'b1100;
    run_session(1'b0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/voter_session.md
Name: voter_session

Overview:
Parametrised, clocked successor to the 4-input combinational voter. It runs a timed voting session for N_VOTERS voters. Each voter may cast one ballot inside a window, and the block then counts yes, no and abstain ballots. It reports a registered one-hot pass/tie/fail verdict in either simple-majority or quorum mode. It sits between the per-voter input logic and the result display/logging logic.

Parameters:
N_VOTERS, 4, number of voters (at least 1)
WINDOW, 8, maximum number of OPEN cycles per session (at least 1)
QUORUM, 3, yes count needed to pass in quorum mode (1..N_VOTERS)
CNT_W, $clog2(N_VOTERS+1), width of the counts; a derived localparam that is not overridable

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request to open a session; honoured only in IDLE
abort  in  1  cancels an open session
mode  in  1  0 = simple majority, 1 = quorum; latched at start
vote_valid  in  N_VOTERS  per-voter ballot strobe
vote_val  in  N_VOTERS  per-voter ballot value: 1 = yes, 0 = no
busy  out  1  high in OPEN and EVAL
done  out  1  one-cycle pulse when a verdict is published
result  out  3  one-hot {pass, tie, fail}; 3'b000 when no verdict
yes_cnt  out  CNT_W  number of yes ballots
no_cnt  out  CNT_W  number of no ballots
abst_cnt  out  CNT_W  number of voters that did not vote
dup_err  out  1  sticky flag: a voter strobed again after its first ballot

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE. All outputs are 0, including the internal voted/ballot registers and the timer.
- The state machine has three states: IDLE, OPEN, EVAL.
- IDLE to OPEN:
  - Taken on a cycle where start = 1.
  - On that edge: mode is latched, voted/ballot/timer are cleared, dup_err and result are cleared, and the counts are cleared.
- OPEN, each cycle, for each voter i with vote_valid[i] = 1:
  - If voted[i] = 0: set voted[i] = 1 and ballot[i] = vote_val[i].
  - If voted[i] = 1: the ballot is unchanged and dup_err is set. dup_err then holds until the next accepted start.
- OPEN exit conditions, checked after this cycle's votes are applied, in priority order:
  - abort = 1 goes to IDLE. No done pulse, result stays 3'b000, counts stay 0.
  - All voters voted, or timer == WINDOW-1, goes to EVAL.
  - Otherwise the timer increments.
- Simultaneous votes from several voters in the same cycle are all accepted. A vote arriving in the closing cycle counts.
- EVAL lasts one cycle:
  - yes_cnt = popcount(voted & ballot).
  - no_cnt = popcount(voted & ~ballot).
  - abst_cnt = N_VOTERS - yes_cnt - no_cnt.
  - result is set, done = 1 for this single cycle, and the next state is IDLE.
  - Counts, done and result are registered outputs, so they become visible on the cycle after EVAL.
- Latency: if cycle k is the last OPEN cycle, done is high in cycle k+2 with result and counts valid. result and counts hold until the next accepted start.
- Mode 0 (simple majority):
  - pass if yes > no; tie if yes == no (0/0 is a tie); fail otherwise.
- Mode 1 (quorum):
  - pass if yes >= QUORUM, fail otherwise; tie is never produced.
- Ignored inputs:
  - start in OPEN or EVAL is ignored.
  - abort in IDLE or EVAL is ignored.
  - vote_valid in IDLE or EVAL is ignored and does not set dup_err.
- start and abort high in the same IDLE cycle: start wins.
- Reset asserted mid-session: immediate return to IDLE with all outputs 0. No done pulse.
- Arithmetic: CNT_W is sized so that N_VOTERS never overflows the counts, and yes + no + abst = N_VOTERS always.

Test Plan:
All scenarios use N_VOTERS=4, WINDOW=8, QUORUM=3.
1. Reset: rst_n = 0 mid-run -> busy=0, done=0, result=3'b000, all counts 0, dup_err=0, asynchronously.
2. Early close: mode=0, start; OPEN cycle 0 vote_valid=4'b0111, vote_val=4'b0111; OPEN cycle 2 vote_valid=4'b1000, vote_val=0 -> EVAL next cycle, done 2 cycles after OPEN cycle 2, yes=3, no=1, abst=0, result=3'b100.
3. Timeout tie: mode=0; voter0 yes, voter1 no, voters 2-3 silent -> exactly 8 OPEN cycles, then done; yes=1, no=1, abst=2, result=3'b010. A separate run with no votes at all gives tie with abst=4.
4. Duplicate: voter0 yes in cycle 0, then voter0 no in cycle 3 -> ballot stays yes, dup_err=1 from the cycle-3 edge until the next start; the final count includes a single yes for voter0.
5. Quorum: mode=1 with 2 yes, 0 no -> result=3'b001. mode=1 with 3 yes, 1 no -> 3'b100. Toggling mode during OPEN has no effect.
6. Cancel/ignore:
   - abort in OPEN cycle 4 -> IDLE next cycle, no done, result=3'b000.
   - start pulsed while busy -> no restart, the original session completes normally.
   - start and abort together in IDLE -> session opens.
